// File: rtl/mux_nto1_reg.sv
// Registered N-channel, W-bit multiplexer with manual select or masked round-robin scan.
// The output register is a one-deep buffer with a valid/ready handshake; it can refill on the cycle it drains.
module mux_nto1_reg #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] d,
    input  logic [SW-1:0]  sel,
    input  logic           en_n,
    input  logic           mode,
    input  logic [N-1:0]   ch_mask,
    output logic [W-1:0]   y,
    output logic [SW-1:0]  y_ch,
    output logic           y_valid,
    input  logic           y_ready,
    output logic           sel_err
);

    logic          load;
    logic          sel_ok;
    logic [W-1:0]  sel_data;
    logic          found_hi;
    logic          found_lo;
    logic [SW-1:0] cand_hi;
    logic [SW-1:0] cand_lo;
    logic [W-1:0]  data_hi;
    logic [W-1:0]  data_lo;
    logic [SW-1:0] cand;
    logic [W-1:0]  cand_data;
    logic [SW-1:0] cand_next;
    logic [SW-1:0] scan_ptr;

    assign load = !en_n && (!y_valid || y_ready);

    // Manual path: a select at or beyond N matches no channel, which flags the error.
    always_comb begin
        sel_ok   = 1'b0;
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SW'(k)) begin
                sel_ok   = 1'b1;
                sel_data = d[k*W +: W];
            end
        end
    end

    // Cyclic search from scan_ptr: first masked channel at or above the pointer,
    // otherwise the lowest masked channel overall (the wrapped part of the search).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        cand_hi  = '0;
        cand_lo  = '0;
        data_hi  = '0;
        data_lo  = '0;
        for (int k = 0; k < N; k++) begin
            if (!found_hi && ch_mask[k] && (SW'(k) >= scan_ptr)) begin
                found_hi = 1'b1;
                cand_hi  = SW'(k);
                data_hi  = d[k*W +: W];
            end
            if (!found_lo && ch_mask[k]) begin
                found_lo = 1'b1;
                cand_lo  = SW'(k);
                data_lo  = d[k*W +: W];
            end
        end
    end

    assign cand      = found_hi ? cand_hi : cand_lo;
    assign cand_data = found_hi ? data_hi : data_lo;
    assign cand_next = (cand == SW'(N-1)) ? '0 : cand + SW'(1);

    // Output register, handshake and scan pointer. A disable drops any held sample
    // without waiting for the consumer but keeps the scan position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y        <= '0;
            y_ch     <= '0;
            y_valid  <= 1'b0;
            sel_err  <= 1'b0;
            scan_ptr <= '0;
        end else if (en_n) begin
            y       <= '0;
            y_ch    <= '0;
            y_valid <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            sel_err <= 1'b0;
            if (load) begin
                if (mode) begin
                    if (found_lo) begin
                        y        <= cand_data;
                        y_ch     <= cand;
                        y_valid  <= 1'b1;
                        scan_ptr <= cand_next;
                    end else begin
                        y_valid <= 1'b0;
                    end
                end else if (sel_ok) begin
                    y       <= sel_data;
                    y_ch    <= sel;
                    y_valid <= 1'b1;
                end else begin
                    y_valid <= 1'b0;
                    sel_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Table-driven scoreboard bench for mux_nto1_reg, exercising N=4 and N=5 instances
// with fixed channel data; expected outputs are written by hand into the vector tables.
module tb_mux_nto1_reg;

    typedef struct {
        logic       dut;
        logic       en_n;
        logic       mode;
        logic [2:0] sel;
        logic [4:0] mask;
        logic       rdy;
        logic [7:0] ey;
        logic [2:0] ech;
        logic       ev;
        logic       ee;
        logic       chk_data;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        en_n;
    logic        mode;
    logic        y_ready;
    logic [31:0] d4;
    logic [39:0] d5;
    logic [1:0]  sel4;
    logic [2:0]  sel5;
    logic [3:0]  mask4;
    logic [4:0]  mask5;
    logic [7:0]  y4;
    logic [7:0]  y5;
    logic [1:0]  ych4;
    logic [2:0]  ych5;
    logic        yv4;
    logic        yv5;
    logic        err4;
    logic        err5;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec;
    int   n_fail;

    mux_nto1_reg #(.N(4), .W(8)) u4 (
        .clk(clk), .rst(rst), .d(d4), .sel(sel4), .en_n(en_n), .mode(mode),
        .ch_mask(mask4), .y(y4), .y_ch(ych4), .y_valid(yv4), .y_ready(y_ready),
        .sel_err(err4)
    );

    mux_nto1_reg #(.N(5), .W(8)) u5 (
        .clk(clk), .rst(rst), .d(d5), .sel(sel5), .en_n(en_n), .mode(mode),
        .ch_mask(mask5), .y(y5), .y_ch(ych5), .y_valid(yv5), .y_ready(y_ready),
        .sel_err(err5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic dut, input logic en_n_v, input logic mode_v,
                                input logic [2:0] sel_v, input logic [4:0] mask_v,
                                input logic rdy_v, input logic [7:0] ey, input logic [2:0] ech,
                                input logic ev, input logic ee, input logic chk_data);
        vec_t v;
        v.dut = dut; v.en_n = en_n_v; v.mode = mode_v; v.sel = sel_v; v.mask = mask_v;
        v.rdy = rdy_v; v.ey = ey; v.ech = ech; v.ev = ev; v.ee = ee; v.chk_data = chk_data;
        return v;
    endfunction

    task automatic compareOutputs(input string name, input vec_t e);
        logic [7:0] ay;
        logic [2:0] ach;
        logic       av;
        logic       ae;
        if (e.dut == 1'b0) begin
            ay = y4; ach = {1'b0, ych4}; av = yv4; ae = err4;
        end else begin
            ay = y5; ach = ych5; av = yv5; ae = err5;
        end
        n_vec++;
        if (av !== e.ev || ae !== e.ee || (e.chk_data && (ay !== e.ey || ach !== e.ech))) begin
            n_fail++;
            $display("[TB] FAIL %s: got y=%h ch=%0d valid=%b err=%b, want y=%h ch=%0d valid=%b err=%b",
                     name, ay, ach, av, ae, e.ey, e.ech, e.ev, e.ee);
        end
    endtask

    task automatic checkOutput(input int idx);
        vec_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL vec%0d: scoreboard empty", idx);
        end else begin
            e = sb.pop_front();
            compareOutputs($sformatf("vec%0d", idx), e);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        en_n    = v.en_n;
        mode    = v.mode;
        sel4    = v.sel[1:0];
        sel5    = v.sel;
        mask4   = v.mask[3:0];
        mask5   = v.mask;
        y_ready = v.rdy;
        sb.push_back(v);
        @(posedge clk);
        #1;
        checkOutput(idx);
    endtask

    task automatic runTable(input int base);
        for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], base + i);
        tbl.delete();
    endtask

    initial begin
        n_vec   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        en_n    = 1'b1;
        mode    = 1'b0;
        y_ready = 1'b0;
        sel4    = '0;
        sel5    = '0;
        mask4   = '0;
        mask5   = '0;
        d4      = {8'h44, 8'h33, 8'h22, 8'h11};
        d5      = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

        #12;
        compareOutputs("reset_n4", mk(0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1));
        compareOutputs("reset_n5", mk(1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1));
        @(negedge clk);
        rst = 1'b0;

        // N=4: idle, manual stepping, backpressure, masked scan, pointer hold, mode switch, disable
        tbl.push_back(mk(0, 1, 0, 0, 5'b00000, 1, 8'h00, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 5'b00000, 1, 8'h11, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 5'b00000, 1, 8'h22, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2, 5'b00000, 1, 8'h33, 2, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 3, 5'b00000, 1, 8'h44, 3, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 5'b00000, 1, 8'h22, 1, 1, 0, 1));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 0, 0, 3, 5'b00000, 0, 8'h22, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 3, 5'b00000, 1, 8'h44, 3, 1, 0, 1));
        for (int k = 0; k < 2; k++) begin
            tbl.push_back(mk(0, 0, 1, 0, 5'b01011, 1, 8'h11, 0, 1, 0, 1));
            tbl.push_back(mk(0, 0, 1, 0, 5'b01011, 1, 8'h22, 1, 1, 0, 1));
            tbl.push_back(mk(0, 0, 1, 0, 5'b01011, 1, 8'h44, 3, 1, 0, 1));
        end
        tbl.push_back(mk(0, 0, 1, 0, 5'b01011, 1, 8'h11, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 5'b00000, 1, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 5'b01011, 1, 8'h22, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2, 5'b01011, 1, 8'h33, 2, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 2, 5'b01011, 1, 8'h44, 3, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 5'b00000, 1, 8'h11, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 5'b00000, 0, 8'h11, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 5'b00000, 0, 8'h00, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 2, 5'b00000, 0, 8'h33, 2, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 2, 5'b01111, 1, 8'h11, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 3, 5'b00100, 0, 8'h11, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 3, 5'b00100, 1, 8'h33, 2, 1, 0, 1));
        runTable(0);

        // Asynchronous reset between edges while a sample is held
        #2;
        rst = 1'b1;
        #1;
        compareOutputs("async_rst_n4", mk(0, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1));
        @(negedge clk);
        rst = 1'b0;

        // N=5: single-bit mask on the top channel, then out-of-range manual select
        tbl.push_back(mk(1, 1, 0, 0, 5'b00000, 1, 8'h00, 0, 0, 0, 1));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1, 0, 1, 0, 5'b10000, 1, 8'h55, 4, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 7, 5'b10000, 1, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 4, 5'b10000, 1, 8'h55, 4, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 5, 5'b10000, 1, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 5'b10000, 1, 8'h11, 0, 1, 0, 1));
        runTable(100);

        #2;
        rst = 1'b1;
        #1;
        compareOutputs("async_rst_n5", mk(1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1));
        @(negedge clk);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
